reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with a per-register busy scoreboard.
// Register 0 is hard-wired to zero and is never busy. Reads are combinational.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to the read
// ports. Without it, reads return only stored contents.
module reg_file_mp #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_WR-1:0]               WE,
   input  logic [NUM_WR*ADDRESS_WIDTH-1:0] AD_W,
   input  logic [NUM_WR*DATA_WIDTH-1:0]    WD,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0] AD_R,
   output logic [NUM_RD*DATA_WIDTH-1:0]    RD,
   input  logic                            ISS_EN,
   input  logic [ADDRESS_WIDTH-1:0]        ISS_AD,
   output logic [NUM_RD-1:0]               BUSY_R,
   output logic [DATA_WIDTH-1:0]           a0
);

   localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_reg;
   logic [NUM_REGS-1:0]   busy_next;

   // Store write data; a later port in the loop overrides an earlier one,
   // so the highest-index port wins on an address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_reg[r] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (WE[w] && (AD_W[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
               regs_reg[AD_W[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= WD[w*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Scoreboard update: committed writes clear, then issue sets (issue wins).
   always_comb begin
      busy_next = busy_reg;
      for (int w = 0; w < NUM_WR; w++) begin
         if (WE[w] && (AD_W[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
            busy_next[AD_W[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b0;
         end
      end
      if (ISS_EN && (ISS_AD != '0)) begin
         busy_next[ISS_AD] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Busy bits register; reset discards all pending state.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   // One combinational read path per port.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDRESS_WIDTH-1:0] addr;
         logic [DATA_WIDTH-1:0]    data;
         logic                     busy;

         assign addr = AD_R[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];

`ifdef REG_FILE_BYPASS_EN
         // Stored value, overridden by the highest matching same-cycle write.
         always_comb begin
            data = (addr == '0) ? '0 : regs_reg[addr];
            busy = (addr != '0) && busy_reg[addr];
            for (int w = 0; w < NUM_WR; w++) begin
               if (!rst && WE[w] && (addr != '0) &&
                   (AD_W[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] == addr)) begin
                  data = WD[w*DATA_WIDTH +: DATA_WIDTH];
                  busy = ISS_EN && (ISS_AD == addr);
               end
            end
         end
`else
         assign data = (addr == '0) ? '0 : regs_reg[addr];
         assign busy = (addr != '0) && busy_reg[addr];
`endif

         assign RD[gi*DATA_WIDTH +: DATA_WIDTH] = data;
         assign BUSY_R[gi] = busy;
      end

      // Architectural view of register 10, never bypassed.
      if (NUM_REGS > 10) begin : g_a0
         assign a0 = regs_reg[10];
      end else begin : g_no_a0
         assign a0 = '0;
      end
   endgenerate

endmodule
